// File: rtl/mips_bus_interface.sv
// mips_bus_interface: single-outstanding load/store/fetch unit bridging the MIPS core to an Avalon-MM master.
// Optional waitrequest timeout abort enabled by defining MIPS_BUS_TIMEOUT_EN.
module mips_bus_interface #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2;

    if (TIMEOUT < 1 || TIMEOUT >= 2 ** TIMEOUT_W) begin : g_bad_timeout
        $error("TIMEOUT does not fit in TIMEOUT_W bits");
    end

    logic [1:0]  state, sz_q, ofs_q;
    logic        wr_q, sgn_q, is_byte, is_half, mis, expire;
    logic [31:0] sh, ext;

    assign is_byte = req_size == 2'b00;
    assign is_half = req_size == 2'b01;
    assign mis     = (is_half & req_addr[0]) | (!is_byte & !is_half & (req_addr[1:0] != 2'b00));

    // Half loads are aligned, so a byte-offset shift also lands the halfword at bit 0.
    assign sh = readdata >> {ofs_q, 3'b000};
    always_comb ext = sz_q == 2'b00 ? {{24{sgn_q & sh[7]}}, sh[7:0]} :
                      sz_q == 2'b01 ? {{16{sgn_q & sh[15]}}, sh[15:0]} : readdata;

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign read      = (state == BUS) & ~wr_q;
    assign write     = (state == BUS) & wr_q;
    assign busy      = state != IDLE;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;

`ifdef MIPS_BUS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt;
    assign expire = waitrequest && cnt == TIMEOUT_W'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (state != BUS) cnt <= '0;
        else if (waitrequest) cnt <= cnt + 1'b1;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            sgn_q      <= 1'b0;
            sz_q       <= 2'b00;
            ofs_q      <= 2'b00;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr_q       <= req_write;
                    sgn_q      <= req_signed;
                    sz_q       <= req_size;
                    ofs_q      <= req_addr[1:0];
                    address    <= {req_addr[31:2], 2'b00};
                    byteenable <= is_byte ? 4'b0001 << req_addr[1:0] :
                                  is_half ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                    writedata  <= is_byte ? {4{req_wdata[7:0]}} :
                                  is_half ? {2{req_wdata[15:0]}} : req_wdata;
                    if (mis) begin
                        state     <= RESP;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state <= BUS;
                    end
                end
                BUS: if (!waitrequest) begin
                    state     <= RESP;
                    rsp_error <= 1'b0;
                    rsp_rdata <= wr_q ? '0 : ext;
                end else if (expire) begin
                    state     <= RESP;
                    rsp_error <= 1'b1;
                    rsp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
